// File: rtl/quiz_round_ctrl_pkg.sv
// quiz_round_ctrl_pkg: state codes, player constants and arbitration helpers for the quiz responder
package quiz_round_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_LOCKED  = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_FOUL    = 3'd4
    } state_e;

    localparam logic [1:0] PLAYER1      = 2'd0;
    localparam logic [7:0] DEF_ANS_TIME = 8'h30;

    function automatic logic [7:0] sanitize_time(input logic [7:0] t, input logic [7:0] def);
        return (t[7:4] > 4'd9 || t[3:0] > 4'd9 || t == 8'h00) ? def : t;
    endfunction

    // Scanning downwards lets the requester closest at-or-after ptr overwrite the others.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] w;
        w = ptr;
        for (int i = 3; i >= 0; i--)
            if (req[ptr + 2'(i)]) w = ptr + 2'(i);
        return w;
    endfunction

endpackage

// File: rtl/quiz_round_ctrl_bcd_down_timer.sv
// quiz_round_ctrl_bcd_down_timer: 1 Hz prescaler driving a 2-digit BCD countdown that stops at 00
module quiz_round_ctrl_bcd_down_timer #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic [7:0] value_i,
    input  logic       run_i,
    output logic       zero_o,
    output logic [3:0] tens_o,
    output logic [3:0] units_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    h_q, h_d, l_q, l_d;
    logic          tick;

    assign tick    = cnt_q == CW'(TICK_DIV - 1);
    assign zero_o  = {h_q, l_q} == 8'h00;
    assign tens_o  = h_q;
    assign units_o = l_q;

    always_comb begin
        cnt_d = cnt_q;
        h_d   = h_q;
        l_d   = l_q;
        if (clr_i) begin
            cnt_d = '0;
            h_d   = 4'd0;
            l_d   = 4'd0;
        end else if (load_i) begin
            cnt_d = '0;
            h_d   = value_i[7:4];
            l_d   = value_i[3:0];
        end else if (run_i && !zero_o) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            l_d   = tick ? ((l_q == 4'd0) ? 4'd9 : l_q - 4'd1) : l_q;
            h_d   = (tick && l_q == 4'd0) ? h_q - 4'd1 : h_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            h_q   <= 4'd0;
            l_q   <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
            h_q   <= h_d;
            l_q   <= l_d;
        end
    end

endmodule

// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl: 4-player quiz round sequencer with round-robin first-press arbiter,
// foul detection, BCD answer countdown and retriggerable buzzer pulse
module quiz_round_ctrl
    import quiz_round_ctrl_pkg::*;
#(
    parameter int         TICK_DIV    = 50_000_000,
    parameter logic [7:0] DEF_TIME    = DEF_ANS_TIME,
    parameter int         BUZZ_CYCLES = 25_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] Key_In,
    input  logic       Host_Arm,
    input  logic       Host_Clear,
    input  logic [7:0] Ans_Time,
    output logic [3:0] LED_Out,
    output logic [3:0] Player_Number,
    output logic [3:0] TimerH,
    output logic [3:0] TimerL,
    output logic       Timer_Run,
    output logic       Block_Sel,
    output logic       Buzzer_Enable,
    output logic       Time_Over,
    output logic       Foul,
    output logic [2:0] State
);

    localparam int BW = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;

    state_e        state_q, state_d;
    logic [3:0]    key_q, kedge_q;
    logic          arm_q, arm_e_q, clr_q, clr_e_q;
    logic [1:0]    win_q, win_d, ptr_q, ptr_d;
    logic          bon_q, bon_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          load, buzz_trig, tzero, held, buzz_last;

    quiz_round_ctrl_bcd_down_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk_i   (CLK),
        .rst_i   (RST),
        .clr_i   (clr_e_q),
        .load_i  (load),
        .value_i (sanitize_time(Ans_Time, DEF_TIME)),
        .run_i   (state_q == ST_LOCKED),
        .zero_o  (tzero),
        .tens_o  (TimerH),
        .units_o (TimerL)
    );

    // Host_Clear outranks every other event, including a same-cycle key edge or tick.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        ptr_d     = ptr_q;
        load      = 1'b0;
        buzz_trig = 1'b0;
        if (clr_e_q) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|kedge_q) begin
                        state_d   = ST_FOUL;
                        win_d     = rr_pick(kedge_q, PLAYER1);
                        buzz_trig = 1'b1;
                    end else if (arm_e_q) begin
                        state_d = ST_ARMED;
                        load    = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (|kedge_q) begin
                        state_d   = ST_LOCKED;
                        win_d     = rr_pick(kedge_q, ptr_q);
                        ptr_d     = win_d + 2'd1;
                        buzz_trig = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (tzero) begin
                        state_d   = ST_TIMEOUT;
                        buzz_trig = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A retrigger restarts the count while the enable stays high, so no gap appears.
    assign buzz_last = bcnt_q == BW'(BUZZ_CYCLES - 1);
    assign bon_d     = !clr_e_q && (buzz_trig || (bon_q && !buzz_last));
    assign bcnt_d    = (clr_e_q || buzz_trig || !bon_q || buzz_last) ? '0 : bcnt_q + 1'b1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            key_q   <= 4'd0;
            kedge_q <= 4'd0;
            arm_q   <= 1'b0;
            arm_e_q <= 1'b0;
            clr_q   <= 1'b0;
            clr_e_q <= 1'b0;
            win_q   <= 2'd0;
            ptr_q   <= PLAYER1;
            bon_q   <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= Key_In;
            kedge_q <= Key_In & ~key_q;
            arm_q   <= Host_Arm;
            arm_e_q <= Host_Arm & ~arm_q;
            clr_q   <= Host_Clear;
            clr_e_q <= Host_Clear & ~clr_q;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            bon_q   <= bon_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign held          = state_q inside {ST_LOCKED, ST_TIMEOUT, ST_FOUL};
    assign LED_Out       = held ? (4'b0001 << win_q) : 4'd0;
    assign Player_Number = held ? {2'b00, win_q} + 4'd1 : 4'd0;
    assign Timer_Run     = state_q == ST_LOCKED;
    assign Block_Sel     = state_q inside {ST_LOCKED, ST_TIMEOUT};
    assign Time_Over     = state_q == ST_TIMEOUT;
    assign Foul          = state_q == ST_FOUL;
    assign Buzzer_Enable = bon_q;
    assign State         = state_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// tb_quiz_round_ctrl: scenario tasks with a winner/timer scoreboard for quiz_round_ctrl
module tb_quiz_round_ctrl;

    logic       CLK = 1'b0, RST = 1'b1;
    logic [3:0] Key_In = 4'd0;
    logic       Host_Arm = 1'b0, Host_Clear = 1'b0;
    logic [7:0] Ans_Time = 8'h03;
    logic [3:0] LED_Out, Player_Number, TimerH, TimerL;
    logic       Timer_Run, Block_Sel, Buzzer_Enable, Time_Over, Foul;
    logic [2:0] State;

    int asserts = 0, failures = 0;
    int exp_q[$];
    int rr = 0;
    int e;

    always #5 CLK = ~CLK;

    quiz_round_ctrl #(.TICK_DIV(10), .DEF_TIME(8'h30), .BUZZ_CYCLES(4)) dut (
        .CLK(CLK), .RST(RST), .Key_In(Key_In), .Host_Arm(Host_Arm), .Host_Clear(Host_Clear),
        .Ans_Time(Ans_Time), .LED_Out(LED_Out), .Player_Number(Player_Number), .TimerH(TimerH),
        .TimerL(TimerL), .Timer_Run(Timer_Run), .Block_Sel(Block_Sel),
        .Buzzer_Enable(Buzzer_Enable), .Time_Over(Time_Over), .Foul(Foul), .State(State)
    );

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic arm(logic [7:0] t);
        Ans_Time = t;
        Host_Arm = 1'b1;
        step();
        Host_Arm = 1'b0;
        step();
    endtask

    task automatic clear();
        Host_Clear = 1'b1;
        step();
        Host_Clear = 1'b0;
        step();
    endtask

    task automatic press(logic [3:0] k);
        Key_In = k;
        step();
        Key_In = 4'd0;
        step();
    endtask

    function automatic int model_pick(logic [3:0] req, int ptr);
        for (int i = 0; i < 4; i++)
            if (req[(ptr + i) % 4]) return (ptr + i) % 4 + 1;
        return 0;
    endfunction

    task automatic push_grant(logic [3:0] k);
        int p;
        p = model_pick(k, rr);
        exp_q.push_back(p);
        rr = p % 4;
    endtask

    task automatic wait_block();
        for (int c = 0; c < 4 && !Block_Sel; c++) step();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step(2);
        asserts++;
        if ({LED_Out, Player_Number, TimerH, TimerL, Timer_Run, Block_Sel, Buzzer_Enable, Time_Over, Foul, State} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %0h expected 0", {LED_Out, Player_Number, TimerH, TimerL, Timer_Run, Block_Sel, Buzzer_Enable, Time_Over, Foul, State});
        end
        RST = 1'b0;
        step();
    endtask

    task automatic test_tie();
        for (int r = 0; r < 2; r++) begin
            arm(8'h05);
            push_grant(4'b1001);
            press(4'b1001);
            wait_block();
            e = exp_q.pop_front();
            asserts++;
            if (Player_Number !== 4'(e) || LED_Out !== 4'(1 << (e - 1))) begin
                failures++;
                $display("FAIL tie_round%0d: got player %0d led %b expected player %0d", r, Player_Number, LED_Out, e);
            end
            clear();
        end
    endtask

    task automatic test_countdown();
        arm(8'h03);
        asserts++;
        if (State !== 3'd1 || {TimerH, TimerL} !== 8'h03) begin
            failures++;
            $display("FAIL armed_load: got state %0d timer %h expected state 1 timer 03", State, {TimerH, TimerL});
        end
        push_grant(4'b0010);
        press(4'b0010);
        wait_block();
        e = exp_q.pop_front();
        asserts++;
        if (Player_Number !== 4'(e) || LED_Out !== 4'b0010 || !Block_Sel || !Timer_Run || State !== 3'd2) begin
            failures++;
            $display("FAIL grant_key2: got player %0d led %b blk %b run %b state %0d expected player %0d led 0010 blk 1 run 1 state 2",
                     Player_Number, LED_Out, Block_Sel, Timer_Run, State, e);
        end
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h00);
        for (int i = 0; i < 3; i++) begin
            step(10);
            e = exp_q.pop_front();
            asserts++;
            if ({TimerH, TimerL} !== 8'(e)) begin
                failures++;
                $display("FAIL countdown_%0d: got %h expected %h", i, {TimerH, TimerL}, 8'(e));
            end
        end
        for (int c = 0; c < 5 && !Time_Over; c++) step();
        asserts++;
        if (!Time_Over || Timer_Run || {TimerH, TimerL} !== 8'h00 || LED_Out !== 4'b0010 || !Buzzer_Enable) begin
            failures++;
            $display("FAIL timeout: got over %b run %b timer %h led %b buzz %b expected 1 0 00 0010 1",
                     Time_Over, Timer_Run, {TimerH, TimerL}, LED_Out, Buzzer_Enable);
        end
        clear();
        asserts++;
        if (State !== 3'd0 || LED_Out !== 4'd0 || {TimerH, TimerL} !== 8'h00) begin
            failures++;
            $display("FAIL clear_after_timeout: got state %0d led %b timer %h expected 0 0000 00", State, LED_Out, {TimerH, TimerL});
        end
    endtask

    task automatic test_foul();
        int n;
        press(4'b0100);
        asserts++;
        if (!Foul || State !== 3'd4 || LED_Out !== 4'b0100 || Player_Number !== 4'd3) begin
            failures++;
            $display("FAIL foul_entry: got foul %b state %0d led %b player %0d expected 1 4 0100 3", Foul, State, LED_Out, Player_Number);
        end
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (Buzzer_Enable) n++;
            step();
        end
        asserts++;
        if (n != 4) begin
            failures++;
            $display("FAIL foul_buzz_len: got %0d cycles expected 4", n);
        end
        arm(8'h05);
        asserts++;
        if (State !== 3'd4 || LED_Out !== 4'b0100) begin
            failures++;
            $display("FAIL foul_ignores_arm: got state %0d led %b expected 4 0100", State, LED_Out);
        end
        clear();
        asserts++;
        if (State !== 3'd0 || Foul || LED_Out !== 4'd0) begin
            failures++;
            $display("FAIL foul_clear: got state %0d foul %b led %b expected 0 0 0000", State, Foul, LED_Out);
        end
    endtask

    task automatic test_bcd_boundary();
        logic [7:0] bad [3];
        bad = '{8'h1A, 8'hA5, 8'h00};
        foreach (bad[i]) begin
            arm(bad[i]);
            asserts++;
            if ({TimerH, TimerL} !== 8'h30) begin
                failures++;
                $display("FAIL default_time_%h: got %h expected 30", bad[i], {TimerH, TimerL});
            end
            clear();
        end
        arm(8'h10);
        push_grant(4'b0001);
        press(4'b0001);
        wait_block();
        e = exp_q.pop_front();
        asserts++;
        if (Player_Number !== 4'(e)) begin
            failures++;
            $display("FAIL grant_rr_wrap: got player %0d expected %0d", Player_Number, e);
        end
        exp_q.push_back(8'h09);
        exp_q.push_back(8'h08);
        for (int i = 0; i < 2; i++) begin
            step(10);
            e = exp_q.pop_front();
            asserts++;
            if ({TimerH, TimerL} !== 8'(e)) begin
                failures++;
                $display("FAIL bcd_borrow_%0d: got %h expected %h", i, {TimerH, TimerL}, 8'(e));
            end
        end
        clear();
    endtask

    task automatic test_clear_vs_key();
        logic bad;
        arm(8'h05);
        Key_In = 4'b0001;
        Host_Clear = 1'b1;
        step();
        Key_In = 4'd0;
        Host_Clear = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (Buzzer_Enable || Block_Sel || LED_Out !== 4'd0) bad = 1'b1;
        end
        asserts++;
        if (State !== 3'd0 || bad) begin
            failures++;
            $display("FAIL clear_beats_key: got state %0d glitch %b expected state 0 glitch 0", State, bad);
        end
    endtask

    task automatic test_reset_mid_locked();
        arm(8'h16);
        push_grant(4'b0100);
        press(4'b0100);
        wait_block();
        e = exp_q.pop_front();
        asserts++;
        if (Player_Number !== 4'(e)) begin
            failures++;
            $display("FAIL grant_before_rst: got player %0d expected %0d", Player_Number, e);
        end
        step(10);
        asserts++;
        if ({TimerH, TimerL} !== 8'h15) begin
            failures++;
            $display("FAIL timer_at_15: got %h expected 15", {TimerH, TimerL});
        end
        #1 RST = 1'b1;
        #1;
        asserts++;
        if ({LED_Out, Player_Number, TimerH, TimerL, Timer_Run, Block_Sel, Buzzer_Enable, Time_Over, Foul, State} !== 27'd0) begin
            failures++;
            $display("FAIL async_reset: got %0h expected 0", {LED_Out, Player_Number, TimerH, TimerL, Timer_Run, Block_Sel, Buzzer_Enable, Time_Over, Foul, State});
        end
        step();
        RST = 1'b0;
        rr = 0;
        step();
        arm(8'h05);
        push_grant(4'b1001);
        press(4'b1001);
        wait_block();
        e = exp_q.pop_front();
        asserts++;
        if (Player_Number !== 4'(e)) begin
            failures++;
            $display("FAIL rr_after_reset: got player %0d expected %0d", Player_Number, e);
        end
        clear();
    endtask

    task automatic test_back_to_back();
        logic [3:0] k;
        for (int r = 0; r < 6; r++) begin
            k = 4'($urandom_range(1, 15));
            arm(8'h09);
            push_grant(k);
            press(k);
            wait_block();
            e = exp_q.pop_front();
            asserts++;
            if (Player_Number !== 4'(e) || LED_Out !== 4'(1 << (e - 1))) begin
                failures++;
                $display("FAIL b2b_round%0d keys %b: got player %0d led %b expected player %0d", r, k, Player_Number, LED_Out, e);
            end
            clear();
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_countdown();
        test_foul();
        test_bcd_boundary();
        test_clear_vs_key();
        test_reset_mid_locked();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
